// File: rtl/bnn_pkg.sv
// Shared widths and state encoding for the binary-neuron evaluation stage.
package bnn_pkg;

   localparam int ACT_W   = 16;
   localparam int BATCH_W = 6;
   localparam int ACC_W   = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } xpu_state_t;

endpackage

// File: rtl/xnor_popcount_unit_popcount16.sv
// Combinational 16-bit population count built as a balanced adder tree.
module popcount16 (
   input  logic [15:0] data_i,
   output logic [4:0]  count_o
);

   logic [1:0] lvl1 [8];
   logic [2:0] lvl2 [4];
   logic [3:0] lvl3 [2];

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lvl1
         assign lvl1[gi] = {1'b0, data_i[2*gi]} + {1'b0, data_i[2*gi+1]};
      end
      for (gi = 0; gi < 4; gi++) begin : g_lvl2
         assign lvl2[gi] = {1'b0, lvl1[2*gi]} + {1'b0, lvl1[2*gi+1]};
      end
      for (gi = 0; gi < 2; gi++) begin : g_lvl3
         assign lvl3[gi] = {1'b0, lvl2[2*gi]} + {1'b0, lvl2[2*gi+1]};
      end
   endgenerate

   assign count_o = {1'b0, lvl3[0]} + {1'b0, lvl3[1]};

endmodule

// File: rtl/xnor_popcount_unit.sv
// XNOR-popcount neuron: accumulate over batch+1 beats, threshold, pack 16 bits.
// Define XNOR_POPCOUNT_PIPE_EN to register the popcount before the accumulator.
module xnor_popcount_unit #(
   parameter int ACT_W = bnn_pkg::ACT_W,
   parameter int ACC_W = bnn_pkg::ACC_W
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        start,
   input  logic [bnn_pkg::BATCH_W-1:0] batch,
   input  logic [ACC_W-1:0]            threshold,
   input  logic [ACT_W-1:0]            activation_in,
   input  logic                        activation_in_valid,
   input  logic [ACT_W-1:0]            weight_in,
   input  logic                        flush,
   output logic                        busy,
   output logic                        neuron_out,
   output logic                        neuron_out_valid,
   output logic [ACC_W-1:0]            acc_out,
   output logic [15:0]                 out_word,
   output logic                        out_word_valid
);

   import bnn_pkg::*;

   xpu_state_t         state_q;
   logic [BATCH_W-1:0] batch_q, cnt_q;
   logic [ACC_W-1:0]   thr_q, acc_q, acc_out_q;
   logic [3:0]         idx_q;
   logic [15:0]        pack_q, out_word_q;
   logic               nout_q, nvalid_q, wvalid_q;

   logic [ACT_W-1:0]   xnor_w;
   logic [4:0]         pc;
   logic [4:0]         acc_add;
   logic               beat, to_done;
   logic [ACC_W-1:0]   acc_d;
   logic               fire_bit;
   logic [15:0]        pack_d;

   assign xnor_w = ~(activation_in ^ weight_in);

   popcount16 u_popcount (
      .data_i  (xnor_w),
      .count_o (pc)
   );

`ifdef XNOR_POPCOUNT_PIPE_EN
   logic [4:0] pc_q;
   logic       pv_q, pl_q;

   // Once the last beat is in flight, further beats must not enter the pipe.
   assign beat    = activation_in_valid && (state_q == ACCUM) && !pl_q;
   assign acc_add = pv_q ? pc_q : 5'd0;
   assign to_done = pv_q && pl_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_q <= '0;
         pv_q <= 1'b0;
         pl_q <= 1'b0;
      end else begin
         pc_q <= pc;
         pv_q <= beat;
         pl_q <= beat && (cnt_q == batch_q);
      end
   end
`else
   assign beat    = activation_in_valid && (state_q == ACCUM);
   assign acc_add = beat ? pc : 5'd0;
   assign to_done = beat && (cnt_q == batch_q);
`endif

   assign acc_d    = acc_q + {{(ACC_W-5){1'b0}}, acc_add};
   assign fire_bit = (acc_q >= thr_q);
   assign pack_d   = pack_q | (16'(fire_bit) << idx_q);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         batch_q    <= '0;
         cnt_q      <= '0;
         thr_q      <= '0;
         acc_q      <= '0;
         acc_out_q  <= '0;
         idx_q      <= '0;
         pack_q     <= '0;
         out_word_q <= '0;
         nout_q     <= 1'b0;
         nvalid_q   <= 1'b0;
         wvalid_q   <= 1'b0;
      end else begin
         nvalid_q <= 1'b0;
         wvalid_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (start) begin
                  batch_q <= batch;
                  thr_q   <= threshold;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= ACCUM;
               end
            end
            ACCUM: begin
               acc_q <= acc_d;
               if (beat) cnt_q <= cnt_q + 6'd1;
               if (to_done) state_q <= DONE;
            end
            DONE: begin
               nout_q    <= fire_bit;
               nvalid_q  <= 1'b1;
               acc_out_q <= acc_q;
               state_q   <= IDLE;
            end
            default: state_q <= IDLE;
         endcase

         // A flush coinciding with a fire folds that bit in and emits once.
         if (state_q == DONE) begin
            if (flush || (idx_q == 4'd15)) begin
               out_word_q <= pack_d;
               wvalid_q   <= 1'b1;
               pack_q     <= '0;
               idx_q      <= '0;
            end else begin
               pack_q <= pack_d;
               idx_q  <= idx_q + 4'd1;
            end
         end else if (flush && (idx_q != 4'd0)) begin
            out_word_q <= pack_q;
            wvalid_q   <= 1'b1;
            pack_q     <= '0;
            idx_q      <= '0;
         end
      end
   end

   assign busy             = (state_q != IDLE);
   assign neuron_out       = nout_q;
   assign neuron_out_valid = nvalid_q;
   assign acc_out          = acc_out_q;
   assign out_word         = out_word_q;
   assign out_word_valid   = wvalid_q;

endmodule

// File: tb/tb_xnor_popcount_unit.sv
// Randomized self-checking bench for xnor_popcount_unit against a behavioural model.
module tb_xnor_popcount_unit;

`ifdef XNOR_POPCOUNT_PIPE_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  batch = '0;
   logic [10:0] threshold = '0;
   logic [15:0] activation_in = '0;
   logic        activation_in_valid = 1'b0;
   logic [15:0] weight_in = '0;
   logic        flush = 1'b0;
   logic        busy, neuron_out, neuron_out_valid, out_word_valid;
   logic [10:0] acc_out;
   logic [15:0] out_word;

   int checks = 0;
   int errors = 0;

   logic [15:0] act_v [64];
   logic [15:0] wt_v  [64];

   // Model of the packing register: pending bits and their count.
   logic [15:0] mp   = '0;
   int          midx = 0;

   xnor_popcount_unit dut (
      .clk                 (clk),
      .resetn              (resetn),
      .start               (start),
      .batch               (batch),
      .threshold           (threshold),
      .activation_in       (activation_in),
      .activation_in_valid (activation_in_valid),
      .weight_in           (weight_in),
      .flush               (flush),
      .busy                (busy),
      .neuron_out          (neuron_out),
      .neuron_out_valid    (neuron_out_valid),
      .acc_out             (acc_out),
      .out_word            (out_word),
      .out_word_valid      (out_word_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_neuron(input int nb, input int thr, input bit gaps,
                             input int restart_at, input bit flush_fire, input string name);
      int          exp_acc;
      bit          exp_bit, exp_wv, seen;
      logic [15:0] exp_word, x;
      int          lat;
      exp_acc = 0;
      for (int i = 0; i <= nb; i++) begin
         x = ~(act_v[i] ^ wt_v[i]);
         exp_acc += $countones(x);
      end
      exp_bit = (exp_acc >= thr);

      start = 1'b1; batch = 6'(nb); threshold = 11'(thr);
      tick();
      start = 1'b0; batch = 6'($urandom); threshold = 11'($urandom);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_after_start got=%0b exp=1", name, busy);
      end

      for (int i = 0; i <= nb; i++) begin
         if (gaps) begin
            int g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
               activation_in = 16'($urandom); weight_in = 16'($urandom);
               tick();
            end
         end
         activation_in = act_v[i]; weight_in = wt_v[i]; activation_in_valid = 1'b1;
         if (i == restart_at) begin
            start = 1'b1; batch = 6'd0; threshold = 11'd0;
         end
         tick();
         start = 1'b0; activation_in_valid = 1'b0;
      end

      seen = 1'b0; lat = 0;
      for (int t = 1; t <= 8 && !seen; t++) begin
         if (flush_fire && t == LAT) flush = 1'b1;
         tick();
         flush = 1'b0;
         if (neuron_out_valid) begin seen = 1'b1; lat = t; end
      end

      checks++;
      if (!seen || lat != LAT) begin
         errors++;
         $display("FAIL %s strobe_latency got=%0d exp=%0d", name, lat, LAT);
      end
      if (seen) begin
         mp[midx] = exp_bit;
         midx++;
         exp_wv = (midx == 16) || flush_fire;
         exp_word = mp;
         if (exp_wv) begin mp = '0; midx = 0; end

         checks++;
         if (acc_out !== 11'(exp_acc) || neuron_out !== exp_bit) begin
            errors++;
            $display("FAIL %s result got acc=%0d bit=%0b exp acc=%0d bit=%0b",
                     name, acc_out, neuron_out, exp_acc, exp_bit);
         end
         checks++;
         if (out_word_valid !== exp_wv || (exp_wv && out_word !== exp_word)) begin
            errors++;
            $display("FAIL %s pack got v=%0b w=%h exp v=%0b w=%h",
                     name, out_word_valid, out_word, exp_wv, exp_word);
         end
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_done got=%0b exp=0", name, busy);
         end
      end
      $display("neuron %s batch=%0d thr=%0d acc=%0d bit=%0b word_v=%0b word=%h",
               name, nb, thr, acc_out, neuron_out, out_word_valid, out_word);
   endtask

   task automatic do_flush(input string name);
      bit          exp_wv;
      logic [15:0] exp_word;
      exp_wv   = (midx > 0);
      exp_word = mp;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      if (exp_wv) begin mp = '0; midx = 0; end
      checks++;
      if (out_word_valid !== exp_wv || (exp_wv && out_word !== exp_word)) begin
         errors++;
         $display("FAIL %s flush got v=%0b w=%h exp v=%0b w=%h",
                  name, out_word_valid, out_word, exp_wv, exp_word);
      end
      $display("flush %s word_v=%0b word=%h", name, out_word_valid, out_word);
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({busy, neuron_out, neuron_out_valid, acc_out, out_word, out_word_valid} !== '0) begin
         errors++;
         $display("FAIL %s outputs_zero got busy=%0b n=%0b nv=%0b acc=%0d w=%h wv=%0b exp all 0",
                  name, busy, neuron_out, neuron_out_valid, acc_out, out_word, out_word_valid);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      resetn = 1'b1;
      tick();
      check_all_zero("post_reset_idle");
      $display("reset busy=%0b acc=%0d word=%h", busy, acc_out, out_word);
   endtask

   task automatic test_single();
      act_v[0] = 16'hFFFF; wt_v[0] = 16'hFFFF;
      run_neuron(0, 16, 1'b0, -1, 1'b0, "single");
   endtask

   task automatic test_gaps();
      act_v[0] = 16'hAAAA; wt_v[0] = 16'h5555;
      act_v[1] = 16'hAAAA; wt_v[1] = 16'h5555;
      act_v[2] = 16'h00FF; wt_v[2] = 16'h00FF;
      act_v[3] = 16'h00FF; wt_v[3] = 16'h00FF;
      run_neuron(3, 33, 1'b1, -1, 1'b0, "gaps");
   endtask

   task automatic test_pack16();
      do_flush("pack16_align");
      act_v[0] = 16'hFFFF; wt_v[0] = 16'hFFFF;
      for (int n = 0; n < 16; n++)
         run_neuron(0, (n % 2 == 0) ? 16 : 17, 1'b0, -1, 1'b0, $sformatf("pack16_%0d", n));
      checks++;
      if (out_word !== 16'h5555) begin
         errors++;
         $display("FAIL pack16_word got=%h exp=5555", out_word);
      end
   endtask

   task automatic test_flush();
      act_v[0] = 16'hFFFF; wt_v[0] = 16'hFFFF;
      run_neuron(0, 16, 1'b0, -1, 1'b0, "flush_n0");
      run_neuron(0, 16, 1'b0, -1, 1'b0, "flush_n1");
      run_neuron(0, 17, 1'b0, -1, 1'b0, "flush_n2");
      do_flush("flush_first");
      checks++;
      if (out_word !== 16'h0003) begin
         errors++;
         $display("FAIL flush_word got=%h exp=0003", out_word);
      end
      do_flush("flush_second");
      run_neuron(0, 16, 1'b0, -1, 1'b0, "flush_fire_n0");
      run_neuron(0, 16, 1'b0, -1, 1'b1, "flush_fire_n1");
   endtask

   task automatic test_start_ignored();
      for (int i = 0; i < 64; i++) begin
         act_v[i] = 16'($urandom); wt_v[i] = act_v[i];
      end
      run_neuron(63, 1024, 1'b0, 5, 1'b0, "start_ignored");
   endtask

   task automatic test_reset_mid();
      start = 1'b1; batch = 6'd3; threshold = 11'd0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         activation_in = 16'hFFFF; weight_in = 16'hFFFF; activation_in_valid = 1'b1;
         tick();
      end
      activation_in_valid = 1'b0;
      resetn = 1'b0;
      #1;
      check_all_zero("reset_mid");
      mp = '0; midx = 0;
      tick();
      #2 resetn = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         act_v[i] = 16'($urandom); wt_v[i] = 16'($urandom);
      end
      run_neuron(3, 30, 1'b1, -1, 1'b0, "after_reset_mid");
   endtask

   task automatic test_random();
      for (int n = 0; n < 10; n++) begin
         int nb, thr;
         nb = $urandom_range(0, 7);
         for (int i = 0; i <= nb; i++) begin
            act_v[i] = 16'($urandom); wt_v[i] = 16'($urandom);
         end
         thr = $urandom_range(0, (nb + 1) * 16);
         run_neuron(nb, thr, 1'($urandom), -1, ($urandom_range(0, 3) == 0),
                    $sformatf("rand_%0d", n));
      end
      do_flush("rand_tail");
   endtask

   initial begin
      test_reset();
      test_single();
      test_gaps();
      test_pack16();
      test_flush();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
